// File: rtl/usb_ahb_pkg.sv
// Shared types for the AHB-Lite manager and the USB endpoint subordinate side.
// Ports: none (package). Provides htrans_t, hsize_t, mgr_state_t and default bus widths.
// Imported by ahb_align_check and ahb_lite_manager.
package usb_ahb_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } hsize_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_ERR,
    S_RESP
  } mgr_state_t;

endpackage

// File: rtl/ahb_lite_manager_if.sv
// Bundles the local command/response handshake and the AHB-Lite bus of the manager.
// Ports: none; signals cmd_* / rsp_* (local side) and h* (AHB side).
// Modports: master = the manager itself, slave = whatever sits around it (controller + subordinate).
interface ahb_lite_manager_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [1:0]        cmd_size;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;

  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [1:0]        hsize;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  logic              hready;
  logic              hresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    input  hrdata, hready, hresp,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata,
    output hsel, haddr, htrans, hwrite, hsize, hwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    output hrdata, hready, hresp,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata,
    input  hsel, haddr, htrans, hwrite, hsize, hwdata
  );

endinterface

// File: rtl/ahb_align_check.sv
// Combinational size/alignment legality check, shared with the subordinate side.
// Ports: size (hsize encoding), addr_lo (two address LSBs) -> legal.
// Byte always legal, half needs bit 0 clear, word needs bits 1:0 clear, size 3 never legal.
module ahb_align_check
  import usb_ahb_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic       legal
);

  always_comb begin
    legal = 1'b0;
    case (size)
      BYTE:    legal = 1'b1;
      HALF:    legal = ~addr_lo[0];
      WORD:    legal = (addr_lo == 2'b00);
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/ahb_lite_manager.sv
// Single-transfer AHB-Lite manager: one command in, one address+data phase out, one response pulse back.
// Ports: clk, n_rst (async active-low), bus (ahb_lite_manager_if.master: cmd_*, rsp_*, AHB h*).
// Optional macro AHB_MGR_RETRY_EN: a bus error on the first attempt re-runs the transfer once.
module ahb_lite_manager
  import usb_ahb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                n_rst,
  ahb_lite_manager_if.master  bus
);

  mgr_state_t        state;
  mgr_state_t        state_nxt;

  // Holding registers: every bus output is sourced from these, never from cmd_* directly.
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              legal;
  logic              accept;
  logic              rd_capture;
  logic              bus_err;
  logic              retry_go;
  logic              fail_set;

`ifdef AHB_MGR_RETRY_EN
  logic              retry_q;
`endif

  ahb_align_check u_align (
    .size    (bus.cmd_size),
    .addr_lo (bus.cmd_addr[1:0]),
    .legal   (legal)
  );

  // Next-state logic
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    rd_capture = 1'b0;
    bus_err    = 1'b0;
    retry_go   = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          accept    = 1'b1;
          state_nxt = legal ? S_ADDR : S_RESP;
        end
      end
      S_ADDR: begin
        if (bus.hready) state_nxt = S_DATA;
      end
      S_DATA: begin
        if (bus.hready) begin
          // hready together with hresp is a one-cycle error: a protocol violation, treated as failure
          if (bus.hresp) begin
            bus_err = 1'b1;
          end else begin
            rd_capture = ~wr_q;
            state_nxt  = S_RESP;
          end
        end else if (bus.hresp) begin
          state_nxt = S_ERR;
        end
      end
      S_ERR: begin
        // Second error cycle is the one with hready high
        if (bus.hready) bus_err = 1'b1;
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (bus_err) begin
`ifdef AHB_MGR_RETRY_EN
      if (!retry_q) begin
        retry_go  = 1'b1;
        state_nxt = S_ADDR;
      end else begin
        state_nxt = S_RESP;
      end
`else
      state_nxt = S_RESP;
`endif
    end
  end

  assign fail_set = bus_err & ~retry_go;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= S_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wr_q    <= bus.cmd_write;
        addr_q  <= bus.cmd_addr;
        size_q  <= bus.cmd_size;
        wdata_q <= bus.cmd_wdata;
        err_q   <= ~legal;
      end
      if (fail_set) err_q <= 1'b1;
      // Loaded on the edge into RESP, so rsp_rdata changes exactly when rsp_valid rises
      if (rd_capture) rdata_q <= bus.hrdata;
    end
  end

`ifdef AHB_MGR_RETRY_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      retry_q <= 1'b0;
    end else if (accept) begin
      retry_q <= 1'b0;
    end else if (retry_go) begin
      retry_q <= 1'b1;
    end
  end
`endif

  // Outputs decode from the state register and holding registers only
  always_comb begin
    bus.cmd_ready = (state == S_IDLE);
    bus.hsel      = (state == S_ADDR) || (state == S_DATA) || (state == S_ERR);
    bus.htrans    = (state == S_ADDR) ? NONSEQ : IDLE;
    bus.haddr     = (state == S_ADDR) ? addr_q : '0;
    bus.hwrite    = (state == S_ADDR) ? wr_q : 1'b0;
    bus.hsize     = (state == S_ADDR) ? size_q : 2'b00;
    bus.hwdata    = ((state == S_DATA) && wr_q) ? wdata_q : '0;
    bus.rsp_valid = (state == S_RESP);
    bus.rsp_err   = (state == S_RESP) && err_q;
    bus.rsp_rdata = rdata_q;
  end

endmodule
